// File: rtl/s_res_sched_pkg.sv
// rtl/s_res_sched_pkg.sv - shared S-bus source codes and sizing for the S result scheduler
package s_res_sched_pkg;

    localparam int SRC_W     = 5;
    localparam int NUM_SREG  = 8;
    localparam int MAX_DELAY = 15;

    typedef enum logic [SRC_W-1:0] {
        SBUS_NONE     = 5'd0,
        SBUS_S_ADD    = 5'd1,
        SBUS_S_LOG    = 5'd2,
        SBUS_S_SHIFT  = 5'd3,
        SBUS_S_POP    = 5'd4,
        SBUS_FP_ADD   = 5'd5,
        SBUS_FP_MUL   = 5'd6,
        SBUS_FP_RECIP = 5'd7,
        SBUS_IMM      = 5'd8,
        SBUS_T_REG    = 5'd9
    } sbus_src_e;

endpackage

// File: rtl/s_res_sched_if.sv
// rtl/s_res_sched_if.sv - issue/write-port bundle of the S result scheduler; S_RES_SCHED_FLUSH_EN adds i_flush
interface s_res_sched_if #(
    parameter int SRC_W    = 5,
    parameter int NUM_SREG = 8
);
    logic                i_issue;
    logic [3:0]          i_delay;
    logic [SRC_W-1:0]    i_src;
    logic                i_s_dest_en;
    logic [2:0]          i_dest;
`ifdef S_RES_SCHED_FLUSH_EN
    logic                i_flush;
`endif
    logic                o_accept;
    logic                o_conflict;
    logic                o_s_wr_en;
    logic [2:0]          o_s_wr_addr;
    logic [SRC_W-1:0]    o_sbus_sel;
    logic [NUM_SREG-1:0] o_s_busy;

    modport master (
`ifdef S_RES_SCHED_FLUSH_EN
        output i_flush,
`endif
        output i_issue, i_delay, i_src, i_s_dest_en, i_dest,
        input  o_accept, o_conflict, o_s_wr_en, o_s_wr_addr, o_sbus_sel, o_s_busy
    );

    modport slave (
`ifdef S_RES_SCHED_FLUSH_EN
        input  i_flush,
`endif
        input  i_issue, i_delay, i_src, i_s_dest_en, i_dest,
        output o_accept, o_conflict, o_s_wr_en, o_s_wr_addr, o_sbus_sel, o_s_busy
    );
endinterface

// File: rtl/s_res_slot.sv
// rtl/s_res_slot.sv - one reservation-line slot: shift from the slot above, insert, or clear
module s_res_slot
    import s_res_sched_pkg::*;
#(
    parameter int SRC_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ins,
    input  logic [SRC_W-1:0] ins_src,
    input  logic [2:0]       ins_dest,
    input  logic             sh_valid,
    input  logic [SRC_W-1:0] sh_src,
    input  logic [2:0]       sh_dest,
    output logic             valid,
    output logic [SRC_W-1:0] src,
    output logic [2:0]       dest,
    output logic             nxt_valid,
    output logic [2:0]       nxt_dest
);
    logic [SRC_W-1:0] nxt_src;

    // Empty slots always hold SBUS_NONE/0 so slot 0 can drive the write port directly.
    always_comb begin
        nxt_valid = sh_valid;
        nxt_src   = sh_src;
        nxt_dest  = sh_dest;
        if (clr) begin
            nxt_valid = 1'b0;
            nxt_src   = SRC_W'(SBUS_NONE);
            nxt_dest  = 3'd0;
        end else if (ins) begin
            nxt_valid = 1'b1;
            nxt_src   = ins_src;
            nxt_dest  = ins_dest;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            src   <= SRC_W'(SBUS_NONE);
            dest  <= 3'd0;
        end else begin
            valid <= nxt_valid;
            src   <= nxt_src;
            dest  <= nxt_dest;
        end
    end
endmodule

// File: rtl/s_res_sched.sv
// rtl/s_res_sched.sv - S-register result scheduler; optional macro S_RES_SCHED_FLUSH_EN adds i_flush
module s_res_sched
    import s_res_sched_pkg::*;
#(
    parameter int MAX_DELAY = 15,
    parameter int SRC_W     = 5,
    parameter int NUM_SREG  = 8
) (
    input logic         clk,
    input logic         rst_n,
    s_res_sched_if.slave bus
);
    // Index MAX_DELAY is a permanently empty phantom slot feeding the top slot.
    logic [MAX_DELAY:0]   v_pad;
    logic [SRC_W-1:0]     s_pad [MAX_DELAY+1];
    logic [2:0]           d_pad [MAX_DELAY+1];
    logic [MAX_DELAY-1:0] nv;
    logic [2:0]           nd    [MAX_DELAY];

    logic                 req;
    logic                 conflict;
    logic                 accept;
    logic                 flush;
    logic [NUM_SREG-1:0]  busy_nxt;
    logic [NUM_SREG-1:0]  busy;

`ifdef S_RES_SCHED_FLUSH_EN
    assign flush = bus.i_flush;
`else
    assign flush = 1'b0;
`endif

    assign req      = bus.i_issue & bus.i_s_dest_en & (bus.i_delay != 4'd0);
    assign conflict = req & v_pad[bus.i_delay];
    assign accept   = req & ~conflict & ~flush;

    assign v_pad[MAX_DELAY] = 1'b0;
    assign s_pad[MAX_DELAY] = SRC_W'(SBUS_NONE);
    assign d_pad[MAX_DELAY] = 3'd0;

    for (genvar k = 0; k < MAX_DELAY; k++) begin : g_slot
        s_res_slot #(.SRC_W(SRC_W)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (flush),
            .ins       (accept && (bus.i_delay == 4'(k + 1))),
            .ins_src   (bus.i_src),
            .ins_dest  (bus.i_dest),
            .sh_valid  (v_pad[k+1]),
            .sh_src    (s_pad[k+1]),
            .sh_dest   (d_pad[k+1]),
            .valid     (v_pad[k]),
            .src       (s_pad[k]),
            .dest      (d_pad[k]),
            .nxt_valid (nv[k]),
            .nxt_dest  (nd[k])
        );
    end

    // Busy is built from next-state slot contents so it lines up with the slots after the edge.
    always_comb begin
        busy_nxt = '0;
        for (int k = 0; k < MAX_DELAY; k++) begin
            if (nv[k]) busy_nxt[nd[k]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    assign bus.o_accept    = accept;
    assign bus.o_conflict  = conflict;
    assign bus.o_s_wr_en   = v_pad[0];
    assign bus.o_s_wr_addr = d_pad[0];
    assign bus.o_sbus_sel  = s_pad[0];
    assign bus.o_s_busy    = busy;
endmodule

// File: doc/s_res_sched.md
Name: s_res_sched

Overview:
S-register result scheduler; consumes the delay/source/dest-enable decode produced per issued instruction and drives the S-register write port at the exact cycle each functional unit result is ready.
- Holds a shift-register reservation line, one slot per future cycle.
- Reports S-bus slot collisions and per-register pending-write status back to issue logic.
- Sits between instruction issue and the S register file / S-bus mux.

Parameters:
MAX_DELAY, 15, number of reservation slots and largest accepted delay
SRC_W, 5, width of S-bus source select code
NUM_SREG, 8, number of S registers (destination field is 3 bits)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
i_issue  input  1  instruction issued this cycle
i_delay  input  4  cycles until result valid
i_src  input  SRC_W  S-bus source code for the result
i_s_dest_en  input  1  instruction writes an S register
i_dest  input  3  destination S register (i field)
o_accept  output  1  combinational; issue with S write accepted this cycle
o_conflict  output  1  combinational; requested slot already taken
o_s_wr_en  output  1  registered S-register write strobe
o_s_wr_addr  output  3  registered write address
o_sbus_sel  output  SRC_W  registered S-bus mux select
o_s_busy  output  NUM_SREG  registered; bit d set while a write to Sd is pending

Behaviour:
- Request: req = i_issue & i_s_dest_en & (i_delay != 0). Delay 0 with dest_en is never scheduled; no conflict is raised.
- Slots 0..MAX_DELAY-1 each hold {valid, src, dest}. Slot 0 drives o_s_wr_en/o_s_wr_addr/o_sbus_sel.
- Every edge: slot k <= slot k+1; top slot <= empty.
- Insertion happens on the same edge, into slot i_delay-1 of the shifted line.
- Timing: request accepted in cycle N produces its write strobe during cycle N+i_delay.
- o_conflict = req & (current slot i_delay).valid. For i_delay = 15, slot 15 does not exist, so there is no conflict.
- o_accept = req & !o_conflict.
- On conflict, nothing is inserted; issue logic must hold and retry. Retry succeeds one cycle later at the same delay if the next slot is free.
- Empty slot 0: o_s_wr_en=0, o_s_wr_addr=0, o_sbus_sel=SBUS_NONE.
- o_s_busy:
  - Registered OR of the decoded dest over all valid slots, computed after the edge.
  - Set from cycle N+1 through the write cycle N+D inclusive.
  - Multiple pending writes to the same register are allowed (WAW ordering is issue logic's job).
- Reset (asynchronous, mid-operation included): all slots invalid, o_s_wr_en=0, o_s_wr_addr=0, o_sbus_sel=SBUS_NONE, o_s_busy=0. Pending results are discarded.
- Outputs are fully registered except o_accept/o_conflict.

Optional Feature:
S_RES_SCHED_FLUSH_EN
- Defined: adds input i_flush (1 bit).
  - When high at an edge, all slots are cleared and no insertion occurs, even if o_accept is high.
  - o_accept is forced 0 while i_flush is high.
  - Used on exchange/error abort.
- Undefined: port absent; slots clear only on reset.

Decomposition:
- Shared package/header: SBUS_* source codes (including SBUS_NONE), SRC_W, S register count.
- Natural sub-module: s_res_slot, one slot register with shift-in/insert mux, instantiated MAX_DELAY times.
- Busy OR-reduction and conflict lookup stay in the top level.

Test Plan:
- Reset mid-stream: schedule D=5 to S3, assert rst_n=0 two cycles later -> all outputs 0, o_sbus_sel=SBUS_NONE, no strobe ever appears.
- Single issue: D=3, src=SBUS_S_ADD, dest=S2 in cycle 10 -> o_s_wr_en=1, addr=2, sel=SBUS_S_ADD in cycle 13 only; o_s_busy[2] high cycles 11-13.
- Collision: cycle 10 D=4 to S1; cycle 11 D=3 to S5 -> o_conflict=1, o_accept=0 in cycle 11. Retry in cycle 12 with D=3 -> accepted, writes in cycles 14 (S1) and 15 (S5).
- Back-to-back interleave: cycle 0 D=14 (FP recip), cycle 1 D=1 (imm), cycle 2 D=6 -> three distinct strobes at cycles 2, 8, 14, no conflicts.
- Non-write and zero delay: i_s_dest_en=0 with D=4, and i_s_dest_en=1 with D=0 -> no strobe, o_accept=0, o_conflict=0.
- Max delay boundary: D=15 while all slots are full -> accepted, write at N+15. With S_RES_SCHED_FLUSH_EN, i_flush at N+3 -> no write, o_s_busy=0 from N+4.
